div_seq_ctrl: RTL and testbench

- Operand sequencer and result collector for the 8-bit non-restoring divider core. It sits directly upstream of the core's in_bus/begin_div and directly downstream of its fin/out_bus.
- Accepts a dividend/divisor pair over a valid/ready request port, serialises the operands onto the shared 8-bit bus, and waits for completion.
- Collects remainder and quotient from the core's time-multiplexed output bus and presents them as one response on a valid/ready port.
- Adds divide-by-zero bypass and a completion watchdog.

---
 rtl/div_seq_ctrl.sv | 195 +++++++++++++++++++
 tb/tb_div_seq_ctrl.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/div_seq_ctrl.sv
// -----------------------------------------------------------------------------
// div_seq_ctrl
//
// Operand sequencer and result collector for the 8-bit non-restoring divider
// core. It takes one dividend/divisor pair over a valid/ready request port and
// places the two operands on the core's shared bus: the dividend with
// div_begin, then the divisor. It then waits for div_fin. The core returns the
// remainder in the div_fin cycle and the quotient in the following cycle. Both
// values are returned together on a valid/ready response port.
//
// A zero divisor is handled here and the core is never started. A watchdog
// ends the wait if the core never completes.
//
// Ports:
//   clk           system clock, rising edge
//   rst           asynchronous reset, active low
//   req_valid     request valid
//   req_ready     request ready (high only in IDLE)
//   req_dividend  dividend, unsigned
//   req_divisor   divisor, unsigned
//   div_in_bus    operand bus to the divider core
//   div_begin     start strobe to the divider core (LD_Q only)
//   div_fin       divider completion flag
//   div_out_bus   divider result bus (remainder, then quotient)
//   rsp_valid     response valid (high only in RESP)
//   rsp_ready     response ready
//   rsp_quotient  quotient
//   rsp_remainder remainder
//   rsp_dbz       divide-by-zero flag
//   rsp_timeout   watchdog flag
// -----------------------------------------------------------------------------
module div_seq_ctrl #(
    parameter int W              = 8,   // tied to the core bus width
    parameter int TIMEOUT_CYCLES = 32   // legal range 16..255
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic [W-1:0] req_dividend,
    input  logic [W-1:0] req_divisor,
    output logic [W-1:0] div_in_bus,
    output logic         div_begin,
    input  logic         div_fin,
    input  logic [W-1:0] div_out_bus,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic [W-1:0] rsp_quotient,
    output logic [W-1:0] rsp_remainder,
    output logic         rsp_dbz,
    output logic         rsp_timeout
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LD_Q,
        S_LD_M,
        S_WAIT,
        S_CAP_Q,
        S_RESP
    } state_t;

    state_t       r_state;
    state_t       w_next;
    logic [W-1:0] r_dividend;
    logic [W-1:0] r_divisor;
    logic [W-1:0] r_quotient;
    logic [W-1:0] r_remainder;
    logic         r_dbz;
    logic         r_timeout;
    logic [7:0]   r_wd_cnt;
    logic         w_accept;
    logic         w_wd_expire;

    assign w_accept = (r_state == S_IDLE) && req_valid;

    // The counter holds k-1 in the k-th WAIT cycle. The watchdog therefore
    // fires at the end of WAIT cycle number TIMEOUT_CYCLES. A div_fin in that
    // same cycle wins.
    assign w_wd_expire = (r_state == S_WAIT) && !div_fin &&
                         (r_wd_cnt == 8'(TIMEOUT_CYCLES - 1));

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the values from before the edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // NOTE: each output of this block is given a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    always_comb begin
        w_next     = r_state;
        req_ready  = 1'b0;
        div_begin  = 1'b0;
        div_in_bus = '0;
        rsp_valid  = 1'b0;
        case (r_state)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    w_next = (req_divisor == '0) ? S_RESP : S_LD_Q;
                end
            end
            S_LD_Q: begin
                div_begin  = 1'b1;
                div_in_bus = r_dividend;
                w_next     = S_LD_M;
            end
            S_LD_M: begin
                div_in_bus = r_divisor;
                w_next     = S_WAIT;
            end
            S_WAIT: begin
                if (div_fin) begin
                    w_next = S_CAP_Q;
                end else if (w_wd_expire) begin
                    w_next = S_RESP;
                end
            end
            S_CAP_Q: begin
                w_next = S_RESP;
            end
            S_RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    w_next = S_IDLE;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Operand, result and watchdog registers. The result registers change only
    // outside RESP, so the response holds steady under backpressure.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_dividend  <= '0;
            r_divisor   <= '0;
            r_quotient  <= '0;
            r_remainder <= '0;
            r_dbz       <= 1'b0;
            r_timeout   <= 1'b0;
            r_wd_cnt    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_dividend <= req_dividend;
                        r_divisor  <= req_divisor;
                        r_timeout  <= 1'b0;
                        if (req_divisor == '0) begin
                            r_quotient  <= '1;
                            r_remainder <= req_dividend;
                            r_dbz       <= 1'b1;
                        end else begin
                            r_quotient  <= '0;
                            r_remainder <= '0;
                            r_dbz       <= 1'b0;
                        end
                    end
                end
                S_LD_M: begin
                    r_wd_cnt <= '0;
                end
                S_WAIT: begin
                    r_wd_cnt <= r_wd_cnt + 8'd1;
                    if (div_fin) begin
                        r_remainder <= div_out_bus;
                    end else if (w_wd_expire) begin
                        r_quotient  <= '0;
                        r_remainder <= '0;
                        r_timeout   <= 1'b1;
                    end
                end
                S_CAP_Q: begin
                    r_quotient <= div_out_bus;
                end
                default: begin
                end
            endcase
        end
    end

    assign rsp_quotient  = r_quotient;
    assign rsp_remainder = r_remainder;
    assign rsp_dbz       = r_dbz;
    assign rsp_timeout   = r_timeout;

endmodule

// File: tb/tb_div_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_div_seq_ctrl
//
// Directed bench for div_seq_ctrl. The bench drives a model divider core
// itself. Each expected response is computed from the request operands and
// queued when the request is sent. It is popped and compared when the DUT
// presents the response.
// -----------------------------------------------------------------------------
module tb_div_seq_ctrl;

    localparam int W  = 8;
    localparam int TO = 32;

    logic         clk;
    logic         rst;
    logic         req_valid;
    logic         req_ready;
    logic [W-1:0] req_dividend;
    logic [W-1:0] req_divisor;
    logic [W-1:0] div_in_bus;
    logic         div_begin;
    logic         div_fin;
    logic [W-1:0] div_out_bus;
    logic         rsp_valid;
    logic         rsp_ready;
    logic [W-1:0] rsp_quotient;
    logic [W-1:0] rsp_remainder;
    logic         rsp_dbz;
    logic         rsp_timeout;

    typedef struct packed {
        logic [7:0] q;
        logic [7:0] r;
        logic       dbz;
        logic       to;
    } rsp_t;

    rsp_t exp_q[$];
    int   n_vec     = 0;
    int   n_err     = 0;
    int   begin_cnt = 0;
    logic rdy_tied  = 1'b0;

    div_seq_ctrl #(.W(W), .TIMEOUT_CYCLES(TO)) dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_dividend  (req_dividend),
        .req_divisor   (req_divisor),
        .div_in_bus    (div_in_bus),
        .div_begin     (div_begin),
        .div_fin       (div_fin),
        .div_out_bus   (div_out_bus),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_quotient  (rsp_quotient),
        .rsp_remainder (rsp_remainder),
        .rsp_dbz       (rsp_dbz),
        .rsp_timeout   (rsp_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Counts the cycles with div_begin high, sampled mid-cycle.
    always @(negedge clk) if (div_begin) begin_cnt++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic rsp_t model(input logic [7:0] a, input logic [7:0] b);
        rsp_t m;
        if (b == 8'd0) m = '{q: 8'hFF, r: a, dbz: 1'b1, to: 1'b0};
        else           m = '{q: a / b, r: a % b, dbz: 1'b0, to: 1'b0};
        return m;
    endfunction

    // Waits (bounded) for IDLE and performs one request handshake. On return
    // the accept edge has just passed.
    task automatic do_req(input logic [7:0] a, input logic [7:0] b, input bit push);
        int n = 0;
        while (!req_ready && n < 100) begin
            tick();
            n++;
        end
        check("req_ready_wait", 32'(req_ready), 32'd1);
        req_valid    = 1'b1;
        req_dividend = a;
        req_divisor  = b;
        tick();
        req_valid    = 1'b0;
        if (push) exp_q.push_back(model(a, b));
    endtask

    // Model core for one nonzero-divisor transaction. It is called in LD_Q and
    // asserts fin in WAIT cycle n. It returns in the first RESP cycle.
    task automatic run_core(input logic [7:0] a, input logic [7:0] b, input int n,
                            input logic [7:0] rem, input logic [7:0] quo);
        check("ldq_begin", 32'(div_begin), 32'd1);
        check("ldq_bus", 32'(div_in_bus), 32'(a));
        tick();
        check("ldm_begin", 32'(div_begin), 32'd0);
        check("ldm_bus", 32'(div_in_bus), 32'(b));
        tick();
        check("wait_bus", 32'(div_in_bus), 32'd0);
        repeat (n - 1) tick();
        div_fin     = 1'b1;
        div_out_bus = rem;
        tick();
        div_fin     = 1'b0;
        div_out_bus = quo;
        check("capq_no_valid", 32'(rsp_valid), 32'd0);
        tick();
        div_out_bus = '0;
        check("resp_valid_rise", 32'(rsp_valid), 32'd1);
    endtask

    // Waits (bounded) for a response, checks it against the scoreboard and
    // hands it off.
    task automatic collect();
        int   n = 0;
        rsp_t e;
        rsp_t o;
        while (!rsp_valid && n < 100) begin
            tick();
            n++;
        end
        check("rsp_valid_wait", 32'(rsp_valid), 32'd1);
        check("rsp_req_ready", 32'(req_ready), 32'd0);
        check("sb_nonempty", 32'(exp_q.size() > 0), 32'd1);
        e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
        o = '{q: rsp_quotient, r: rsp_remainder, dbz: rsp_dbz, to: rsp_timeout};
        check("rsp_q_r_dbz_to", 32'(o), 32'(e));
        rsp_ready = 1'b1;
        tick();
        rsp_ready = rdy_tied;
        check("handoff_valid", 32'(rsp_valid), 32'd0);
        check("handoff_req_ready", 32'(req_ready), 32'd1);
    endtask

    initial begin
        int b0;
        rst          = 1'b0;
        req_valid    = 1'b0;
        req_dividend = '0;
        req_divisor  = '0;
        div_fin      = 1'b0;
        div_out_bus  = '0;
        rsp_ready    = 1'b0;

        // Reset values
        #3;
        check("rst_req_ready", 32'(req_ready), 32'd1);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_begin", 32'(div_begin), 32'd0);
        check("rst_bus", 32'(div_in_bus), 32'd0);
        check("rst_results", {14'd0, rsp_quotient, rsp_remainder, rsp_dbz, rsp_timeout}, 32'd0);
        tick();
        tick();
        rst = 1'b1;
        tick();

        // Basic divide 100/7: fin in WAIT cycle 10, response 13 edges after accept
        b0 = begin_cnt;
        do_req(8'd100, 8'd7, 1'b1);
        run_core(8'd100, 8'd7, 10, 8'd2, 8'd14);
        check("basic_begin_cycles", 32'(begin_cnt - b0), 32'd1);
        collect();

        // Divide by zero: response on the next cycle, core never started
        b0 = begin_cnt;
        do_req(8'd200, 8'd0, 1'b1);
        check("dbz_valid_next", 32'(rsp_valid), 32'd1);
        collect();
        check("dbz_no_begin", 32'(begin_cnt - b0), 32'd0);

        // Backpressure 255/16: response held for 5 cycles
        do_req(8'd255, 8'd16, 1'b1);
        run_core(8'd255, 8'd16, 4, 8'd15, 8'd15);
        repeat (5) begin
            check("bp_valid", 32'(rsp_valid), 32'd1);
            check("bp_req_ready", 32'(req_ready), 32'd0);
            check("bp_hold", {16'd0, rsp_quotient, rsp_remainder}, {16'd0, exp_q[0].q, exp_q[0].r});
            tick();
        end
        collect();

        // Watchdog: no fin, timeout response after exactly TO WAIT cycles
        do_req(8'd77, 8'd3, 1'b0);
        exp_q.push_back('{q: 8'd0, r: 8'd0, dbz: 1'b0, to: 1'b1});
        tick();
        tick();
        repeat (TO - 1) tick();
        check("wd_pre_valid", 32'(rsp_valid), 32'd0);
        tick();
        check("wd_valid", 32'(rsp_valid), 32'd1);
        collect();

        // fin in the same cycle the watchdog would expire: normal result wins
        do_req(8'd60, 8'd7, 1'b1);
        run_core(8'd60, 8'd7, TO, 8'd4, 8'd8);
        collect();

        // Reset mid-WAIT: abandoned, a late fin produces nothing
        do_req(8'd99, 8'd9, 1'b0);
        repeat (4) tick();
        #2;
        rst = 1'b0;
        #1;
        check("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("midrst_req_ready", 32'(req_ready), 32'd1);
        check("midrst_begin", 32'(div_begin), 32'd0);
        tick();
        rst         = 1'b1;
        div_fin     = 1'b1;
        div_out_bus = 8'd5;
        tick();
        div_fin     = 1'b0;
        div_out_bus = '0;
        repeat (3) begin
            check("late_fin_no_rsp", 32'(rsp_valid), 32'd0);
            check("late_fin_idle", 32'(req_ready), 32'd1);
            tick();
        end
        do_req(8'd9, 8'd3, 1'b1);
        run_core(8'd9, 8'd3, 2, 8'd0, 8'd3);
        collect();

        // Back-to-back with rsp_ready tied high
        rdy_tied  = 1'b1;
        rsp_ready = 1'b1;
        do_req(8'd50, 8'd5, 1'b1);
        run_core(8'd50, 8'd5, 3, 8'd0, 8'd10);
        collect();
        do_req(8'd7, 8'd9, 1'b1);
        run_core(8'd7, 8'd9, 5, 8'd7, 8'd0);
        collect();
        do_req(8'd0, 8'd1, 1'b1);
        run_core(8'd0, 8'd1, 1, 8'd0, 8'd0);
        collect();
        check("sb_drained", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_time_limit: observed no finish expected finish");
        $fatal(1, "time limit");
    end

endmodule
